// File: rtl/mips_ctrl_pipe_pkg.sv
// Shared declarations for the pipelined MIPS control path: forwarding
// select encoding and the per-stage control bundles that mips_ctrl_pipe
// carries from EX to WB. The optional MIPS_FORWARDING_EN build changes
// only hazard_unit, not these types.
package mips_decls_p;

    localparam int REGADDR_W_DEF = 5;
    localparam int ALUCTL_W_DEF  = 3;

    // ALU operand source: register file, WB-stage result or MEM-stage result.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Single-bit controls still needed once the instruction reaches EX.
    typedef struct packed {
        logic memtoreg;
        logic memwrite;
        logic alusrc;
        logic regdst;
        logic regwrite;
        logic branch;
    } ctrl_e_t;

    // Controls still needed once the instruction reaches MEM.
    typedef struct packed {
        logic memtoreg;
        logic memwrite;
        logic regwrite;
    } ctrl_m_t;

    // Controls still needed once the instruction reaches WB.
    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } ctrl_w_t;

    // Drop the EX-only fields when a bundle moves from EX to MEM.
    function automatic ctrl_m_t ctrl_e_to_m(input ctrl_e_t c);
        ctrl_m_t r;
        r.memtoreg = c.memtoreg;
        r.memwrite = c.memwrite;
        r.regwrite = c.regwrite;
        return r;
    endfunction

    // Drop the MEM-only fields when a bundle moves from MEM to WB.
    function automatic ctrl_w_t ctrl_m_to_w(input ctrl_m_t c);
        ctrl_w_t r;
        r.memtoreg = c.memtoreg;
        r.regwrite = c.regwrite;
        return r;
    endfunction

endpackage

// File: rtl/mips_ctrl_pipe_hazard.sv
// hazard_unit: purely combinational stall, flush, redirect and forwarding
// logic for the five-stage MIPS pipeline.
// With MIPS_FORWARDING_EN defined, EX operands are forwarded from MEM/WB
// and the only data stall is load-use. Without it, forwarding selects stay
// at FWD_RF and any ID source that matches a pending EX or MEM write stalls.
// Register 0 is never treated as a dependency. A taken branch (pcsrc_e)
// overrides stalls and jumps since both belong to the wrong path.
module hazard_unit
    import mips_decls_p::*;
#(
    parameter int REGADDR_W = REGADDR_W_DEF
) (
    input  logic [REGADDR_W-1:0] rs_d,
    input  logic [REGADDR_W-1:0] rt_d,
    input  logic                 jump_d,
    input  logic [REGADDR_W-1:0] rs_e,
    input  logic [REGADDR_W-1:0] rt_e,
    input  logic                 memtoreg_e,
    input  logic                 regwrite_e,
    input  logic                 branch_e,
    input  logic                 zero_e,
    input  logic [REGADDR_W-1:0] writereg_e,
    input  logic                 regwrite_m,
    input  logic [REGADDR_W-1:0] writereg_m,
    input  logic                 regwrite_w,
    input  logic [REGADDR_W-1:0] writereg_w,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 pcsrc_e,
    output logic                 jump_go,
    output logic [1:0]           forward_a_e,
    output logic [1:0]           forward_b_e
);

    localparam logic [REGADDR_W-1:0] R0 = '0;

`ifdef MIPS_FORWARDING_EN
    // Newest producer wins: MEM before WB, register 0 never forwarded.
    function automatic fwd_sel_t fwd_pick(input logic [REGADDR_W-1:0] src,
                                          input logic rw_m, input logic [REGADDR_W-1:0] wr_m,
                                          input logic rw_w, input logic [REGADDR_W-1:0] wr_w);
        fwd_sel_t s;
        s = FWD_RF;
        if (src != R0 && rw_m && wr_m == src)
            s = FWD_MEM;
        else if (src != R0 && rw_w && wr_w == src)
            s = FWD_WB;
        return s;
    endfunction

    logic unused_nofwd_inputs;
    assign unused_nofwd_inputs = ^{regwrite_e, writereg_e};
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs_e, regwrite_w, writereg_w};
`endif

    // Stall, flush, redirect and forward decisions for the current cycle.
    always_comb begin
        logic lwstall;
        logic depstall;
        fwd_sel_t fa;
        fwd_sel_t fb;

        lwstall  = memtoreg_e && (rt_e != R0) && ((rt_e == rs_d) || (rt_e == rt_d));
        depstall = 1'b0;
        fa       = FWD_RF;
        fb       = FWD_RF;

`ifdef MIPS_FORWARDING_EN
        fa = fwd_pick(rs_e, regwrite_m, writereg_m, regwrite_w, writereg_w);
        fb = fwd_pick(rt_e, regwrite_m, writereg_m, regwrite_w, writereg_w);
`else
        // WB producers are safe: the register file writes on the falling edge.
        depstall = ((rs_d != R0) && ((regwrite_e && writereg_e == rs_d) ||
                                     (regwrite_m && writereg_m == rs_d))) ||
                   ((rt_d != R0) && ((regwrite_e && writereg_e == rt_d) ||
                                     (regwrite_m && writereg_m == rt_d)));
`endif

        pcsrc_e     = branch_e & zero_e;
        stall_d     = (lwstall | depstall) & ~pcsrc_e;
        stall_f     = stall_d;
        jump_go     = jump_d & ~stall_d & ~pcsrc_e;
        flush_d     = pcsrc_e | jump_go;
        flush_e     = pcsrc_e | stall_d;
        forward_a_e = fa;
        forward_b_e = fb;
    end

endmodule

// File: rtl/mips_ctrl_pipe.sv
// mips_ctrl_pipe: carries the decoded ID-stage control bundle through the
// ID/EX, EX/MEM and MEM/WB control registers and delivers per-stage
// controls plus hazard decisions to the datapath.
// Optional build macro MIPS_FORWARDING_EN (consumed by hazard_unit)
// selects forwarding versus stall-on-dependency operation.
// ID/EX takes an all-zero bubble when flush_e is high; there is no
// enable, so a stall is realised as a bubble into EX while the front end
// holds. EX/MEM and MEM/WB load every cycle.
module mips_ctrl_pipe
    import mips_decls_p::*;
#(
    parameter int REGADDR_W = REGADDR_W_DEF,
    parameter int ALUCTL_W  = ALUCTL_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memtoreg_d,
    input  logic                 memwrite_d,
    input  logic                 alusrc_d,
    input  logic                 regdst_d,
    input  logic                 regwrite_d,
    input  logic                 branch_d,
    input  logic                 jump_d,
    input  logic [ALUCTL_W-1:0]  alucontrol_d,
    input  logic [REGADDR_W-1:0] rs_d,
    input  logic [REGADDR_W-1:0] rt_d,
    input  logic [REGADDR_W-1:0] writereg_e,
    input  logic                 zero_e,
    output logic                 alusrc_e,
    output logic                 regdst_e,
    output logic [ALUCTL_W-1:0]  alucontrol_e,
    output logic [REGADDR_W-1:0] rs_e,
    output logic [REGADDR_W-1:0] rt_e,
    output logic                 memwrite_m,
    output logic                 regwrite_m,
    output logic [REGADDR_W-1:0] writereg_m,
    output logic [REGADDR_W-1:0] writereg_w,
    output logic                 memtoreg_w,
    output logic                 regwrite_w,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 pcsrc_e,
    output logic                 jump_go,
    output logic [1:0]           forward_a_e,
    output logic [1:0]           forward_b_e
);

    ctrl_e_t                ctrl_e_q, ctrl_e_d;
    logic [ALUCTL_W-1:0]    alucontrol_e_q, alucontrol_e_d;
    logic [REGADDR_W-1:0]   rs_e_q, rs_e_d;
    logic [REGADDR_W-1:0]   rt_e_q, rt_e_d;
    ctrl_m_t                ctrl_m_q, ctrl_m_d;
    logic [REGADDR_W-1:0]   writereg_m_q, writereg_m_d;
    ctrl_w_t                ctrl_w_q, ctrl_w_d;
    logic [REGADDR_W-1:0]   writereg_w_q, writereg_w_d;

    hazard_unit #(.REGADDR_W(REGADDR_W)) u_hazard (
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .jump_d      (jump_d),
        .rs_e        (rs_e_q),
        .rt_e        (rt_e_q),
        .memtoreg_e  (ctrl_e_q.memtoreg),
        .regwrite_e  (ctrl_e_q.regwrite),
        .branch_e    (ctrl_e_q.branch),
        .zero_e      (zero_e),
        .writereg_e  (writereg_e),
        .regwrite_m  (ctrl_m_q.regwrite),
        .writereg_m  (writereg_m_q),
        .regwrite_w  (ctrl_w_q.regwrite),
        .writereg_w  (writereg_w_q),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .pcsrc_e     (pcsrc_e),
        .jump_go     (jump_go),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e)
    );

    // Next-state for all three control registers; flush_e turns ID/EX into a bubble.
    always_comb begin
        ctrl_e_d       = '0;
        alucontrol_e_d = '0;
        rs_e_d         = '0;
        rt_e_d         = '0;
        if (!flush_e) begin
            ctrl_e_d.memtoreg = memtoreg_d;
            ctrl_e_d.memwrite = memwrite_d;
            ctrl_e_d.alusrc   = alusrc_d;
            ctrl_e_d.regdst   = regdst_d;
            ctrl_e_d.regwrite = regwrite_d;
            ctrl_e_d.branch   = branch_d;
            alucontrol_e_d    = alucontrol_d;
            rs_e_d            = rs_d;
            rt_e_d            = rt_d;
        end
        ctrl_m_d     = ctrl_e_to_m(ctrl_e_q);
        writereg_m_d = writereg_e;
        ctrl_w_d     = ctrl_m_to_w(ctrl_m_q);
        writereg_w_d = writereg_m_q;
    end

    // Stage registers; an async reset discards every in-flight bundle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e_q       <= '0;
            alucontrol_e_q <= '0;
            rs_e_q         <= '0;
            rt_e_q         <= '0;
            ctrl_m_q       <= '0;
            writereg_m_q   <= '0;
            ctrl_w_q       <= '0;
            writereg_w_q   <= '0;
        end else begin
            ctrl_e_q       <= ctrl_e_d;
            alucontrol_e_q <= alucontrol_e_d;
            rs_e_q         <= rs_e_d;
            rt_e_q         <= rt_e_d;
            ctrl_m_q       <= ctrl_m_d;
            writereg_m_q   <= writereg_m_d;
            ctrl_w_q       <= ctrl_w_d;
            writereg_w_q   <= writereg_w_d;
        end
    end

    assign alusrc_e     = ctrl_e_q.alusrc;
    assign regdst_e     = ctrl_e_q.regdst;
    assign alucontrol_e = alucontrol_e_q;
    assign rs_e         = rs_e_q;
    assign rt_e         = rt_e_q;
    assign memwrite_m   = ctrl_m_q.memwrite;
    assign regwrite_m   = ctrl_m_q.regwrite;
    assign writereg_m   = writereg_m_q;
    assign writereg_w   = writereg_w_q;
    assign memtoreg_w   = ctrl_w_q.memtoreg;
    assign regwrite_w   = ctrl_w_q.regwrite;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Bench for mips_ctrl_pipe: directed hazard scenarios followed by random
// instruction streams with occasional mid-stream resets, all checked
// against a stage-slot model of the pipeline built from the hazard rules.
// Honours MIPS_FORWARDING_EN the same way the design does.
module tb_mips_ctrl_pipe;
    import mips_decls_p::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       memtoreg_d, memwrite_d, alusrc_d, regdst_d, regwrite_d, branch_d, jump_d;
    logic [2:0] alucontrol_d;
    logic [4:0] rs_d, rt_d, writereg_e;
    logic       zero_e;
    logic       alusrc_e, regdst_e;
    logic [2:0] alucontrol_e;
    logic [4:0] rs_e, rt_e, writereg_m, writereg_w;
    logic       memwrite_m, regwrite_m, memtoreg_w, regwrite_w;
    logic       stall_f, stall_d, flush_d, flush_e, pcsrc_e, jump_go;
    logic [1:0] forward_a_e, forward_b_e;

    mips_ctrl_pipe dut (
        .clk(clk), .reset(reset),
        .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d), .alusrc_d(alusrc_d),
        .regdst_d(regdst_d), .regwrite_d(regwrite_d), .branch_d(branch_d), .jump_d(jump_d),
        .alucontrol_d(alucontrol_d), .rs_d(rs_d), .rt_d(rt_d),
        .writereg_e(writereg_e), .zero_e(zero_e),
        .alusrc_e(alusrc_e), .regdst_e(regdst_e), .alucontrol_e(alucontrol_e),
        .rs_e(rs_e), .rt_e(rt_e), .memwrite_m(memwrite_m), .regwrite_m(regwrite_m),
        .writereg_m(writereg_m), .writereg_w(writereg_w),
        .memtoreg_w(memtoreg_w), .regwrite_w(regwrite_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .pcsrc_e(pcsrc_e), .jump_go(jump_go),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
    );

    // Clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: one record per occupied pipeline slot.
    typedef struct {
        logic memtoreg, memwrite, alusrc, regdst, regwrite, branch;
        logic [2:0] alu;
        logic [4:0] rs, rt;
    } slot_e_t;
    typedef struct {
        logic memtoreg, memwrite, regwrite;
        logic [4:0] wr;
    } slot_mw_t;

    slot_e_t  s_e, n_e;
    slot_mw_t s_m, s_w, n_m, n_w;

    logic       x_pc, x_stall, x_jg, x_fd, x_fe;
    logic [1:0] x_fa, x_fb;

    logic       o_stall, o_jg, o_fd, o_fe, o_pc;
    logic [1:0] o_fa, o_fb;

    task automatic model_clear();
        s_e = '{default: '0};
        s_m = '{default: '0};
        s_w = '{default: '0};
    endtask

    function automatic logic [1:0] pick(input logic [4:0] src);
        if (src != 0 && s_m.regwrite && s_m.wr == src) return 2'd2;
        if (src != 0 && s_w.regwrite && s_w.wr == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic busy(input logic [4:0] src);
        return src != 0 && ((s_e.regwrite && writereg_e == src) ||
                            (s_m.regwrite && s_m.wr == src));
    endfunction

    task automatic model_eval();
        logic lw, dep;
        x_pc = s_e.branch && zero_e;
        lw   = s_e.memtoreg && s_e.rt != 0 && (s_e.rt == rs_d || s_e.rt == rt_d);
`ifdef MIPS_FORWARDING_EN
        dep  = 1'b0;
        x_fa = pick(s_e.rs);
        x_fb = pick(s_e.rt);
`else
        dep  = busy(rs_d) || busy(rt_d);
        x_fa = 2'd0;
        x_fb = 2'd0;
`endif
        x_stall = (lw || dep) && !x_pc;
        x_jg    = jump_d && !x_stall && !x_pc;
        x_fd    = x_pc || x_jg;
        x_fe    = x_pc || x_stall;
    endtask

    task automatic check_outputs();
        model_eval();
        check("alusrc_e",     alusrc_e,     s_e.alusrc);
        check("regdst_e",     regdst_e,     s_e.regdst);
        check("alucontrol_e", alucontrol_e, s_e.alu);
        check("rs_e",         rs_e,         s_e.rs);
        check("rt_e",         rt_e,         s_e.rt);
        check("memwrite_m",   memwrite_m,   s_m.memwrite);
        check("regwrite_m",   regwrite_m,   s_m.regwrite);
        check("writereg_m",   writereg_m,   s_m.wr);
        check("memtoreg_w",   memtoreg_w,   s_w.memtoreg);
        check("regwrite_w",   regwrite_w,   s_w.regwrite);
        check("writereg_w",   writereg_w,   s_w.wr);
        check("pcsrc_e",      pcsrc_e,      x_pc);
        check("stall_d",      stall_d,      x_stall);
        check("stall_f",      stall_f,      x_stall);
        check("jump_go",      jump_go,      x_jg);
        check("flush_d",      flush_d,      x_fd);
        check("flush_e",      flush_e,      x_fe);
        check("forward_a_e",  forward_a_e,  x_fa);
        check("forward_b_e",  forward_b_e,  x_fb);
    endtask

    // One clock: check at the falling edge, advance the model past the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        o_stall = stall_d; o_jg = jump_go; o_fd = flush_d; o_fe = flush_e;
        o_pc = pcsrc_e; o_fa = forward_a_e; o_fb = forward_b_e;
        if (x_fe) n_e = '{default: '0};
        else n_e = '{memtoreg_d, memwrite_d, alusrc_d, regdst_d, regwrite_d, branch_d,
                     alucontrol_d, rs_d, rt_d};
        n_m = '{s_e.memtoreg, s_e.memwrite, s_e.regwrite, writereg_e};
        n_w = s_m;
        @(posedge clk);
        #1;
        s_e = n_e;
        s_m = n_m;
        s_w = n_w;
    endtask

    task automatic clr_in();
        memtoreg_d = 0; memwrite_d = 0; alusrc_d = 0; regdst_d = 0;
        regwrite_d = 0; branch_d = 0; jump_d = 0; alucontrol_d = '0;
        rs_d = '0; rt_d = '0; writereg_e = '0; zero_e = 0;
    endtask

    task automatic rand_in();
        memtoreg_d   = ($urandom_range(0, 3) == 0);
        memwrite_d   = ($urandom_range(0, 4) == 0);
        alusrc_d     = 1'($urandom_range(0, 1));
        regdst_d     = 1'($urandom_range(0, 1));
        regwrite_d   = ($urandom_range(0, 2) != 0);
        branch_d     = ($urandom_range(0, 4) == 0);
        jump_d       = ($urandom_range(0, 5) == 0);
        alucontrol_d = 3'($urandom_range(0, 7));
        rs_d         = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        rt_d         = 5'($urandom_range(0, 3));
        writereg_e   = 5'($urandom_range(0, 3));
        zero_e       = 1'($urandom_range(0, 1));
    endtask

    // Asynchronous reset in mid-stream, called just after a rising edge.
    task automatic mid_reset();
        reset = 1'b1;
        #1;
        model_clear();
        check_outputs();
        check("rst_regwrite_m", regwrite_m, 1'b0);
        check("rst_regwrite_w", regwrite_w, 1'b0);
        check("rst_forward_a",  forward_a_e, FWD_RF);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clr_in();
        model_clear();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // Reset with a register write in flight.
        clr_in(); regwrite_d = 1; rs_d = 1; rt_d = 2; writereg_e = 3;
        cycle();
        cycle();
        clr_in(); regwrite_d = 1;
        mid_reset();

        // Back-to-back dependent ALU ops.
        clr_in(); regwrite_d = 1; rs_d = 1; rt_d = 2;
        cycle();
        clr_in(); regwrite_d = 1; regdst_d = 1; rs_d = 3; rt_d = 5; writereg_e = 3;
        cycle();
        clr_in(); regwrite_d = 1; regdst_d = 1; rs_d = 3; rt_d = 4; writereg_e = 4;
        cycle();
`ifdef MIPS_FORWARDING_EN
        check("b2b_fwd_mem", o_fa, FWD_MEM);
        check("b2b_no_stall", o_stall, 1'b0);
`endif
        clr_in(); writereg_e = 6;
        cycle();
`ifdef MIPS_FORWARDING_EN
        check("b2b_fwd_wb", o_fa, FWD_WB);
        check("b2b_fwd_b_mem", o_fb, FWD_MEM);
`endif
        clr_in();
        repeat (3) cycle();

        // Load-use.
        clr_in(); memtoreg_d = 1; regwrite_d = 1; rs_d = 1; rt_d = 2;
        cycle();
        clr_in(); regwrite_d = 1; regdst_d = 1; rs_d = 6; rt_d = 2; writereg_e = 2;
        cycle();
        check("lu_stall", o_stall, 1'b1);
        check("lu_flush_e", o_fe, 1'b1);
        writereg_e = 0;
        cycle();
`ifdef MIPS_FORWARDING_EN
        check("lu_release", o_stall, 1'b0);
        clr_in(); writereg_e = 7;
        cycle();
        check("lu_fwd_b_wb", o_fb, FWD_WB);
`else
        check("lu_dep_stall", o_stall, 1'b1);
`endif
        clr_in();
        repeat (3) cycle();

        // Taken branch overriding load-use stall and jump.
        clr_in(); memtoreg_d = 1; branch_d = 1; rt_d = 2;
        cycle();
        clr_in(); rt_d = 2; jump_d = 1; zero_e = 1;
        cycle();
        check("br_pcsrc", o_pc, 1'b1);
        check("br_stall", o_stall, 1'b0);
        check("br_jump_go", o_jg, 1'b0);
        check("br_flush_d", o_fd, 1'b1);
        check("br_flush_e", o_fe, 1'b1);
        clr_in();
        repeat (3) cycle();

        // Jump held by a load-use stall.
        clr_in(); memtoreg_d = 1; regwrite_d = 1; rt_d = 2;
        cycle();
        clr_in(); jump_d = 1; rs_d = 2; writereg_e = 2;
        cycle();
        check("jmp_stall", o_stall, 1'b1);
        check("jmp_held", o_jg, 1'b0);
        writereg_e = 0;
        cycle();
`ifndef MIPS_FORWARDING_EN
        check("jmp_held_dep", o_jg, 1'b0);
        cycle();
`endif
        check("jmp_go", o_jg, 1'b1);
        check("jmp_flush_d", o_fd, 1'b1);
        clr_in();
        repeat (3) cycle();

        // Register 0 destination and EX-stage dependency.
        clr_in(); regwrite_d = 1;
        cycle();
        clr_in(); regwrite_d = 1; rs_d = 0; writereg_e = 0;
        cycle();
        clr_in(); rs_d = 5; writereg_e = 5;
        cycle();
        check("r0_fwd_a", o_fa, FWD_RF);
`ifdef MIPS_FORWARDING_EN
        check("r0_ex_nostall", o_stall, 1'b0);
`else
        check("r0_ex_stall", o_stall, 1'b1);
`endif
        clr_in();
        repeat (3) cycle();

        // Random streams with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            if (i % 500 == 499) mid_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
